// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage
// (instruction port, read-only) and the memory stage (data port).
// One transaction is outstanding at a time; it is sequenced through
// IDLE -> ISSUE -> (WAIT) -> RESP and the response is routed to its owner.
//
// Optional build macro: MEM_ARBITER_ROUND_ROBIN_EN
//   defined   - ties in IDLE go to the port not granted last time
//   undefined - fixed priority, data port over instruction port
//
// Handshake semantics: a request transfers on a rising edge where both
// valid and ready are 1. Requesters hold valid and all request fields
// stable until that edge; ready is only ever offered in IDLE and only to
// the granted port. On the memory side mem_valid and the mem_* fields stay
// stable until the edge where mem_ready is 1. Response pulses
// (i_rsp_valid, d_rsp_valid, mem_rsp_valid) are single-cycle with no ready.
//
// dbg_state exposes the FSM: 0=IDLE, 1=ISSUE, 2=WAIT, 3=RESP.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_rsp_valid,
    output logic [DATA_WIDTH-1:0]   i_rsp_data,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_write,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [1:0]              dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    grant_i;
    logic                    grant_d;
    logic                    capture;
    logic                    owner;      // 0 = instruction port, 1 = data port
    logic [ADDR_WIDTH-1:0]   hold_addr;
    logic                    hold_write;
    logic [DATA_WIDTH-1:0]   hold_wdata;
    logic [STRB_WIDTH-1:0]   hold_wstrb;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_grant;                    // 0 = instruction port, 1 = data port

    // Remember who won the most recent handshake so the next tie flips.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (grant_i || grant_d) begin
            last_grant <= grant_d;
        end
    end

    // Grant in IDLE only; a tie goes to the port that did not win last time.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req_valid && d_req_valid) begin
                grant_d = ~last_grant;
                grant_i = last_grant;
            end else begin
                grant_d = d_req_valid;
                grant_i = i_req_valid;
            end
        end
    end
`else
    // Grant in IDLE only; the data port always wins a tie.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_d = d_req_valid;
            grant_i = i_req_valid & ~d_req_valid;
        end
    end
`endif

    // Ready is the grant itself, so a grant is always a completed handshake.
    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;
    assign dbg_state   = state;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, memory-side outputs and response pulses.
    always_comb begin
        state_nx    = state;
        capture     = 1'b0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_i || grant_d) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                mem_addr  = hold_addr;
                mem_write = hold_write;
                mem_wdata = hold_wdata;
                mem_wstrb = hold_wstrb;
                if (mem_ready) begin
                    if (mem_rsp_valid) begin
                        capture  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                i_rsp_valid = ~owner;
                d_rsp_valid = owner;
                state_nx    = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Latch the winning request; fetches are reads with no byte enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_wdata <= '0;
            hold_wstrb <= '0;
        end else if (grant_i || grant_d) begin
            owner      <= grant_d;
            hold_addr  <= grant_d ? d_req_addr : i_req_addr;
            hold_write <= grant_d & d_req_write;
            hold_wdata <= grant_d ? d_req_wdata : '0;
            hold_wstrb <= grant_d ? d_req_wstrb : '0;
        end
    end

    // Response data lands in the owner's register on the edge entering RESP
    // and then holds until the next response for that port.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_rsp_data <= '0;
            d_rsp_data <= '0;
        end else if (capture) begin
            if (owner) begin
                d_rsp_data <= mem_rsp_data;
            end else begin
                i_rsp_data <= mem_rsp_data;
            end
        end
    end

endmodule
